frame_commit_buffer: RTL

FRAME_COMMIT_BUFFER -- requirements
Module: frame_commit_buffer

---
 rtl/fcb_pkg.sv | 6 +
 rtl/frame_commit_buffer_if.sv | 25 ++
 rtl/fcb_ram.sv | 17 +
 rtl/frame_commit_buffer.sv | 79 +++++++
 4 files changed

// File: rtl/fcb_pkg.sv
// fcb_pkg: shared types and constants for frame_commit_buffer (state enum, word width, default depth).
package fcb_pkg;
    localparam int WORD_W    = 32;
    localparam int DEPTH_DEF = 64;
    typedef enum logic [1:0] {IDLE, RECV, OVF} state_t;
endpackage

// File: rtl/frame_commit_buffer_if.sv
// frame_commit_buffer_if: bus bundle for frame_commit_buffer.
// Ports: axiiv/axiid word input, fcs_done/fcs_kill frame verdict, instr_ready downstream accept,
// instr/instr_valid committed head word, overflow/commit_count/drop_count statistics.
// slave = buffer side, master = environment side.
interface frame_commit_buffer_if;
    import fcb_pkg::*;
    logic              axiiv;
    logic [WORD_W-1:0] axiid;
    logic              fcs_done;
    logic              fcs_kill;
    logic              instr_ready;
    logic [WORD_W-1:0] instr;
    logic              instr_valid;
    logic              overflow;
    logic [7:0]        commit_count;
    logic [7:0]        drop_count;
    modport slave (
        input  axiiv, axiid, fcs_done, fcs_kill, instr_ready,
        output instr, instr_valid, overflow, commit_count, drop_count
    );
    modport master (
        output axiiv, axiid, fcs_done, fcs_kill, instr_ready,
        input  instr, instr_valid, overflow, commit_count, drop_count
    );
endinterface

// File: rtl/fcb_ram.sv
// fcb_ram: word storage, one synchronous write port and one asynchronous read port, contents not reset.
// Ports: clk_50mhz clock; we/waddr/wdata write; raddr/rdata combinational read.
module fcb_ram import fcb_pkg::*; #(
    parameter int AW = 6
) (
    input  logic              clk_50mhz,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clk_50mhz)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/frame_commit_buffer.sv
// frame_commit_buffer: speculative frame buffer; words become readable only once the frame's checksum passes.
// Ports: clk_50mhz clock, rst sync active-high reset, bus (frame_commit_buffer_if.slave) carrying
// word input, checksum verdict, FWFT read side and statistics.
// Macro FCB_STATS_EN: when defined, overflow/commit_count/drop_count are live; otherwise tied to 0.
module frame_commit_buffer import fcb_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
) (
    input logic                  clk_50mhz,
    input logic                  rst,
    frame_commit_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    state_t state, state_n;
    logic [PW-1:0] rd, wr_commit, wr_spec, rd_n, wr_commit_n, wr_spec_n;
    logic [WORD_W-1:0] rdata;
    logic done_q, edge_hit, full, wr_en, ovf_hit, in_frame, commit, drop;
    assign edge_hit = bus.fcs_done & ~done_q;
    assign full     = (wr_spec - rd) == PW'(DEPTH);
    assign ovf_hit  = bus.axiiv & full & (state != OVF);
    assign wr_en    = bus.axiiv & ~full & (state != OVF);
    // a word arriving in IDLE opens a frame in that same cycle, so an edge alongside it resolves it
    assign in_frame = (state == RECV) | ((state == IDLE) & bus.axiiv);
    assign commit   = edge_hit & in_frame & ~ovf_hit & ~bus.fcs_kill;
    assign drop     = edge_hit & ((state == OVF) | ovf_hit | (in_frame & bus.fcs_kill));
    always_comb begin
        rd_n        = rd + PW'(bus.instr_valid & bus.instr_ready);
        wr_spec_n   = drop ? wr_commit : wr_spec + PW'(wr_en);
        wr_commit_n = commit ? wr_spec + PW'(wr_en) : wr_commit;
        state_n     = (commit | drop) ? IDLE : ovf_hit ? OVF : in_frame ? RECV : state;
    end
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state     <= IDLE;
            rd        <= '0;
            wr_commit <= '0;
            wr_spec   <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            rd        <= rd_n;
            wr_commit <= wr_commit_n;
            wr_spec   <= wr_spec_n;
            done_q    <= bus.fcs_done;
        end
    end
    fcb_ram #(.AW(AW)) u_ram (
        .clk_50mhz (clk_50mhz),
        .we        (wr_en & ~rst),
        .waddr     (wr_spec[AW-1:0]),
        .wdata     (bus.axiid),
        .raddr     (rd[AW-1:0]),
        .rdata     (rdata)
    );
    assign bus.instr_valid = rd != wr_commit;
    assign bus.instr       = bus.instr_valid ? rdata : '0;
`ifdef FCB_STATS_EN
    logic       ovf_q;
    logic [7:0] cc, dc;
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            ovf_q <= 1'b0;
            cc    <= '0;
            dc    <= '0;
        end else begin
            if (ovf_hit) ovf_q <= 1'b1;
            if (commit && cc != 8'hff) cc <= cc + 8'd1;
            if (drop && dc != 8'hff) dc <= dc + 8'd1;
        end
    end
    assign bus.overflow     = ovf_q;
    assign bus.commit_count = cc;
    assign bus.drop_count   = dc;
`else
    assign bus.overflow     = 1'b0;
    assign bus.commit_count = '0;
    assign bus.drop_count   = '0;
`endif
endmodule
